// File: rtl/reg_file_if.sv
// ----------------------------------------------------------------------------
// reg_file_if -- bundle of the write-back, issue and read-port signals of
// reg_file.
//
// Signals (directions as seen by the register file, i.e. the slave modport):
//   we, waddr, wdata       in   write-back port
//   issue, issue_addr      in   marks a destination register as pending
//   raddr_a, raddr_b       in   read port indices
//   rdata_a, rdata_b       out  read data (combinational, with write bypass)
//   stall_a, stall_b       out  operand of that port is still in flight
//
// Modports: master (pipeline / bench side), slave (register file side).
// ----------------------------------------------------------------------------
interface reg_file_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
);
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic             issue;
    logic [AW-1:0]    issue_addr;
    logic [AW-1:0]    raddr_a;
    logic [AW-1:0]    raddr_b;
    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;
    logic             stall_a;
    logic             stall_b;

    modport master (
        output we, waddr, wdata, issue, issue_addr, raddr_a, raddr_b,
        input  rdata_a, rdata_b, stall_a, stall_b
    );

    modport slave (
        input  we, waddr, wdata, issue, issue_addr, raddr_a, raddr_b,
        output rdata_a, rdata_b, stall_a, stall_b
    );
endinterface

// File: rtl/reg_file.sv
// ----------------------------------------------------------------------------
// reg_file -- DEPTH x WIDTH register file with a one-bit-per-register
// scoreboard, two combinational read ports and write-to-read bypass.
//
// Ports:
//   clk   in   sole clock, all state changes on the rising edge
//   rst   in   asynchronous, active-low reset (clears registers and busy bits)
//   rf    slave modport of reg_file_if (write-back, issue, read ports A/B)
//
// Parameters: WIDTH (data width), DEPTH (2..256 registers),
//             AW (index width, 2**AW >= DEPTH).
//
// Optional feature: define REG_FILE_ZERO_REG_EN to hard-wire register 0 to
// zero (writes, bypass and issue to index 0 are ignored).
// ----------------------------------------------------------------------------
module reg_file #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        rst,
    reg_file_if.slave   rf
);

`ifdef REG_FILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;

    logic wr_ok;
    logic iss_ok;

    // Index 0 is excluded from both write and issue when it is hard-wired,
    // which also removes it from the bypass path.
    always_comb begin
        wr_ok  = rf.we    && (int'(rf.waddr)      < DEPTH)
                          && !(ZERO_REG && (rf.waddr == '0));
        iss_ok = rf.issue && (int'(rf.issue_addr) < DEPTH)
                          && !(ZERO_REG && (rf.issue_addr == '0));
    end

    // Write-back clears first, then issue sets, so a same-index collision
    // leaves the register pending (a newer producer is in flight).
    always_comb begin
        busy_nxt = busy;
        if (wr_ok)
            busy_nxt[rf.waddr] = 1'b0;
        if (iss_ok)
            busy_nxt[rf.issue_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            busy <= '0;
        end else begin
            if (wr_ok)
                regs[rf.waddr] <= rf.wdata;
            busy <= busy_nxt;
        end
    end

    // Read port A: bypass wins over the stored value and masks the stall.
    always_comb begin
        logic in_rng;
        logic byp;
        in_rng     = (int'(rf.raddr_a) < DEPTH) && !(ZERO_REG && (rf.raddr_a == '0));
        byp        = wr_ok && (rf.waddr == rf.raddr_a);
        rf.rdata_a = '0;
        rf.stall_a = 1'b0;
        if (byp)
            rf.rdata_a = rf.wdata;
        else if (in_rng) begin
            rf.rdata_a = regs[rf.raddr_a];
            rf.stall_a = busy[rf.raddr_a];
        end
    end

    // Read port B: identical to port A.
    always_comb begin
        logic in_rng;
        logic byp;
        in_rng     = (int'(rf.raddr_b) < DEPTH) && !(ZERO_REG && (rf.raddr_b == '0));
        byp        = wr_ok && (rf.waddr == rf.raddr_b);
        rf.rdata_b = '0;
        rf.stall_b = 1'b0;
        if (byp)
            rf.rdata_b = rf.wdata;
        else if (in_rng) begin
            rf.rdata_b = regs[rf.raddr_b];
            rf.stall_b = busy[rf.raddr_b];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// ----------------------------------------------------------------------------
// tb_reg_file -- self-checking bench for reg_file. One instance with the
// default parameters and one with DEPTH=6 for the out-of-range cases.
// ----------------------------------------------------------------------------
module tb_reg_file;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_file_if #(.WIDTH(8), .AW(3)) ifa ();
    reg_file_if #(.WIDTH(8), .AW(3)) ifb ();

    reg_file #(.WIDTH(8), .DEPTH(8), .AW(3)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (ifa.slave)
    );

    reg_file #(.WIDTH(8), .DEPTH(6), .AW(3)) dut6 (
        .clk (clk),
        .rst (rst),
        .rf  (ifb.slave)
    );

`ifdef REG_FILE_ZERO_REG_EN
    localparam logic [7:0] R0_DATA  = 8'h00;
    localparam logic       R0_STALL = 1'b0;
`else
    localparam logic [7:0] R0_DATA  = 8'hFF;
    localparam logic       R0_STALL = 1'b1;
`endif

    typedef struct {
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic       iss;
        logic [2:0] ia;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [7:0] ea;
        logic       sa;
        logic [7:0] eb;
        logic       sb;
    } vec_t;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                                input logic iss, input logic [2:0] ia,
                                input logic [2:0] ra, input logic [2:0] rb,
                                input logic [7:0] ea, input logic sa,
                                input logic [7:0] eb, input logic sb);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.iss = iss; v.ia = ia;
        v.ra = ra; v.rb = rb; v.ea = ea; v.sa = sa; v.eb = eb; v.sb = sb;
        return v;
    endfunction

    task automatic drive_a(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                           input logic iss, input logic [2:0] ia,
                           input logic [2:0] ra, input logic [2:0] rb);
        ifa.we = we; ifa.waddr = wa; ifa.wdata = wd;
        ifa.issue = iss; ifa.issue_addr = ia;
        ifa.raddr_a = ra; ifa.raddr_b = rb;
    endtask

    task automatic drive_b(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                           input logic iss, input logic [2:0] ia,
                           input logic [2:0] ra, input logic [2:0] rb);
        ifb.we = we; ifb.waddr = wa; ifb.wdata = wd;
        ifb.issue = iss; ifb.issue_addr = ia;
        ifb.raddr_a = ra; ifb.raddr_b = rb;
    endtask

    vec_t vecs[15];

    initial begin
        // Expected values are for the register state built up by the
        // preceding vectors; each vector is checked before its own edge.
        vecs[0]  = mk(1, 2, 8'h2A, 0, 0, 2, 2, 8'h2A, 0, 8'h2A, 0);  // bypass both ports
        vecs[1]  = mk(0, 0, 8'h00, 0, 0, 2, 3, 8'h2A, 0, 8'h00, 0);  // stored read
        vecs[2]  = mk(0, 0, 8'h00, 1, 5, 5, 2, 8'h00, 0, 8'h2A, 0);  // issue 5, busy not yet set
        vecs[3]  = mk(0, 0, 8'h00, 0, 0, 5, 5, 8'h00, 1, 8'h00, 1);  // 5 pending on both ports
        vecs[4]  = mk(1, 5, 8'h11, 0, 0, 5, 2, 8'h11, 0, 8'h2A, 0);  // write-back bypass hides stall
        vecs[5]  = mk(0, 0, 8'h00, 0, 0, 5, 5, 8'h11, 0, 8'h11, 0);  // busy cleared
        vecs[6]  = mk(1, 3, 8'h33, 1, 3, 3, 4, 8'h33, 0, 8'h00, 0);  // collision on 3
        vecs[7]  = mk(0, 0, 8'h00, 0, 0, 3, 3, 8'h33, 1, 8'h33, 1);  // issue won, data written
        vecs[8]  = mk(1, 3, 8'h44, 0, 0, 3, 5, 8'h44, 0, 8'h11, 0);  // retire 3
        vecs[9]  = mk(0, 0, 8'h00, 0, 0, 3, 3, 8'h44, 0, 8'h44, 0);
        vecs[10] = mk(1, 0, 8'hFF, 1, 0, 0, 1, R0_DATA, 0, 8'h00, 0); // register 0 write+issue
        vecs[11] = mk(0, 0, 8'h00, 0, 0, 0, 0, R0_DATA, R0_STALL, R0_DATA, R0_STALL);
        vecs[12] = mk(1, 0, 8'hFF, 0, 0, 1, 0, 8'h00, 0, R0_DATA, 0);
        vecs[13] = mk(1, 7, 8'h77, 1, 6, 7, 6, 8'h77, 0, 8'h00, 0);
        vecs[14] = mk(0, 0, 8'h00, 0, 0, 6, 7, 8'h00, 1, 8'h77, 0);

        drive_a(0, 0, 8'h00, 0, 0, 0, 0);
        drive_b(0, 0, 8'h00, 0, 0, 0, 0);

        // ---------------- reset state
        #2;
        chk("reset rdata_a", 32'(ifa.rdata_a), 32'h0);
        chk("reset stall_a", 32'(ifa.stall_a), 32'h0);
        chk("reset rdata_b", 32'(ifa.rdata_b), 32'h0);
        chk("reset stall_b", 32'(ifa.stall_b), 32'h0);

        // A write presented while reset is held across an edge is ignored.
        drive_a(1, 1, 8'h99, 1, 1, 2, 1);
        #1;
        chk("bypass in reset", 32'(ifa.rdata_b), 32'h99);
        @(posedge clk); #1;
        drive_a(0, 0, 8'h00, 0, 0, 1, 1);
        #1;
        chk("held reset data", 32'(ifa.rdata_a), 32'h0);
        chk("held reset stall", 32'(ifa.stall_a), 32'h0);

        @(negedge clk);
        rst = 1'b1;

        // ---------------- table-driven vectors
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive_a(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].iss, vecs[i].ia,
                    vecs[i].ra, vecs[i].rb);
            #1;
            chk($sformatf("v%0d rdata_a", i), 32'(ifa.rdata_a), 32'(vecs[i].ea));
            chk($sformatf("v%0d stall_a", i), 32'(ifa.stall_a), 32'(vecs[i].sa));
            chk($sformatf("v%0d rdata_b", i), 32'(ifa.rdata_b), 32'(vecs[i].eb));
            chk($sformatf("v%0d stall_b", i), 32'(ifa.stall_b), 32'(vecs[i].sb));
        end

        // ---------------- asynchronous reset mid-run (register 6 still busy)
        @(negedge clk);
        drive_a(0, 0, 8'h00, 0, 0, 2, 6);
        #1;
        chk("pre-reset rdata_a", 32'(ifa.rdata_a), 32'h2A);
        chk("pre-reset stall_b", 32'(ifa.stall_b), 32'h1);
        #1;
        rst = 1'b0;
        #1;
        chk("async reset rdata_a", 32'(ifa.rdata_a), 32'h0);
        chk("async reset stall_b", 32'(ifa.stall_b), 32'h0);
        drive_a(0, 0, 8'h00, 0, 0, 7, 5);
        #1;
        chk("async reset rdata 7", 32'(ifa.rdata_a), 32'h0);
        chk("async reset rdata 5", 32'(ifa.rdata_b), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // ---------------- DEPTH=6 instance, out-of-range index 7
        @(negedge clk);
        drive_b(1, 7, 8'hAB, 1, 7, 7, 7);
        #1;
        chk("oor bypass rdata_a", 32'(ifb.rdata_a), 32'h0);
        chk("oor bypass stall_a", 32'(ifb.stall_a), 32'h0);
        @(negedge clk);
        drive_b(1, 6, 8'hCD, 1, 6, 7, 6);
        #1;
        chk("oor read 7 rdata", 32'(ifb.rdata_a), 32'h0);
        chk("oor read 7 stall", 32'(ifb.stall_a), 32'h0);
        chk("oor read 6 rdata", 32'(ifb.rdata_b), 32'h0);
        @(negedge clk);
        drive_b(1, 5, 8'h55, 0, 0, 7, 6);
        #1;
        chk("oor after rdata 7", 32'(ifb.rdata_a), 32'h0);
        chk("oor after stall 6", 32'(ifb.stall_b), 32'h0);
        @(negedge clk);
        drive_b(0, 0, 8'h00, 0, 0, 5, 0);
        for (int r = 0; r < 5; r++) begin
            ifb.raddr_b = 3'(r);
            #1;
            chk($sformatf("d6 reg%0d untouched", r), 32'(ifb.rdata_b), 32'h0);
            chk($sformatf("d6 stall%0d clear", r), 32'(ifb.stall_b), 32'h0);
        end
        chk("d6 reg5 written", 32'(ifb.rdata_a), 32'h55);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter WIDTH, default 8: data width of every register.
REQ-002 Parameter DEPTH, default 8: number of registers, 2..256.
REQ-003 Parameter AW, default 3: address width, SHALL satisfy 2**AW >= DEPTH.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 we  input  1  write-back enable.
REQ-007 waddr  input  AW  write-back register index.
REQ-008 wdata  input  WIDTH  write-back data.
REQ-009 issue  input  1  marks register issue_addr as pending (result in flight).
REQ-010 issue_addr  input  AW  destination index of the issued instruction.
REQ-011 raddr_a, raddr_b  input  AW  read port indices.
REQ-012 rdata_a, rdata_b  output  WIDTH  read data.
REQ-013 stall_a, stall_b  output  1  read operand not yet valid.

Function
REQ-014 Write: on a rising edge with we=1 and waddr<DEPTH, register[waddr] SHALL load wdata. Otherwise the register holds.
REQ-015 Read: rdata_x SHALL be combinational from register[raddr_x], zero-latency.
REQ-016 Bypass: if we=1 and waddr==raddr_x in the same cycle, rdata_x SHALL equal wdata.
REQ-017 Scoreboard: each register SHALL have one busy bit.
- Set on a rising edge with issue=1 (issue_addr<DEPTH).
- Cleared on a rising edge with we=1 for that index.
REQ-018 Simultaneous issue and write to the same index SHALL leave busy=1 (issue wins), with the data still written.
REQ-019 stall_x SHALL be 1 iff busy[raddr_x]=1 and the bypass of REQ-016 does not apply for that port.
REQ-020 Out-of-range index (>=DEPTH):
- Write or issue ignored.
- Read returns 0 with stall_x=0.
REQ-021 Ports A and B SHALL be independent. Identical addresses SHALL return identical rdata/stall.

Reset
REQ-022 While rst=0, all registers and busy bits SHALL be 0 immediately, regardless of clk.
REQ-023 Consequently rdata_a/rdata_b=0 and stall_a/stall_b=0 during reset, except when bypass is active.
REQ-024 An issue or write presented on the edge coinciding with rst deassertion SHALL be ignored. Operation resumes on the next rising edge.

Configuration
REQ-025 Macro REG_FILE_ZERO_REG_EN defined:
- Register 0 SHALL always read 0.
- Writes to register 0 ignored, bypass to register 0 disabled.
- Issue to register 0 never sets busy, so stall is never asserted for index 0.
REQ-026 Macro undefined: register 0 SHALL behave as any other register.

Verification
REQ-027 Reset: rst=0 mid-run after writes -> all reads 0 and stalls 0 without a clock edge.
REQ-028 Write/read: we=1, waddr=2, wdata=8'h2A, then raddr_a=2 -> rdata_a=8'h2A.
- Same cycle with raddr_b=2 -> rdata_b=8'h2A via bypass.
REQ-029 Scoreboard:
- issue=1, issue_addr=5, then raddr_a=5 -> stall_a=1.
- Write-back we=1, waddr=5, wdata=8'h11 -> stall_a=0 and rdata_a=8'h11 that cycle.
- Next cycle busy is cleared.
REQ-030 Collision: issue and we both to index 3 on one edge -> register[3]=wdata and stall on raddr 3 stays 1.
REQ-031 Zero register with REG_FILE_ZERO_REG_EN: we=1, waddr=0, wdata=8'hFF and issue to 0 -> rdata=0, stall=0.
- Without the macro -> rdata=8'hFF.
REQ-032 Parameters: DEPTH=6, AW=3.
- Write to index 7 -> no register changes.
- raddr=7 -> rdata=0, stall=0.
